// File: rtl/ins_cache_nway.sv
// rtl/ins_cache_nway.sv - N-way set-associative instruction-cache tag controller with true LRU
module ins_cache_nway #(
    parameter int ADDR_W     = 32,
    parameter int SETS       = 16384,
    parameter int WAYS       = 2,
    parameter int LINE_BYTES = 64,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        n,
    input  logic [ADDR_W-1:0] add_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    output logic              hit,
    output logic              miss,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int AGE_W = $clog2(WAYS);

    localparam logic [3:0] CMD_FETCH = 4'd2;
    localparam logic [3:0] CMD_INVAL = 4'd3;
    localparam logic [3:0] CMD_RESET = 4'd8;

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOOKUP, S_FILL} state_t;

    state_t state;

    // Per-set, per-way tag state; age 0 is MRU, WAYS-1 is LRU
    logic             valid_mem [SETS][WAYS];
    logic [TAG_W-1:0] tag_mem   [SETS][WAYS];
    logic [AGE_W-1:0] age_mem   [SETS][WAYS];

    logic [3:0]       cmd_q;
    logic [IDX_W-1:0] idx_q;
    logic [TAG_W-1:0] tag_q;
    logic [AGE_W-1:0] vic_q;
    logic [IDX_W-1:0] clr_idx;

    logic             hit_found;
    logic [AGE_W-1:0] hit_way;
    logic             inv_found;
    logic [AGE_W-1:0] inv_way;
    logic [AGE_W-1:0] lru_way;
    logic [AGE_W-1:0] victim;
    logic [AGE_W-1:0] touch_way;
    logic [AGE_W-1:0] touch_age;

    // Line offset bits only select bytes within a line; the tag controller ignores them
    logic unused_off;
    assign unused_off = ^add_in[OFF_W-1:0];

    // Compare the latched tag against every way of the latched set and pick hit way / victim
    always_comb begin
        hit_found = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_mem[idx_q][w] && (tag_mem[idx_q][w] == tag_q) && !hit_found) begin
                hit_found = 1'b1;
                hit_way   = AGE_W'(w);
            end
            if (!valid_mem[idx_q][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = AGE_W'(w);
            end
            if (age_mem[idx_q][w] == AGE_W'(WAYS - 1)) begin
                lru_way = AGE_W'(w);
            end
        end
        victim    = inv_found ? inv_way : lru_way;
        // The way being promoted to MRU: the hit way in LOOKUP, the filled victim in FILL
        touch_way = (state == S_FILL) ? vic_q : hit_way;
        touch_age = age_mem[idx_q][touch_way];
    end

    // Controller FSM: clear sweep, command accept, lookup/update, and fill handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_CLEAR;
            clr_idx    <= '0;
            cmd_ready  <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            hit        <= 1'b0;
            miss       <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            cmd_q      <= '0;
            idx_q      <= '0;
            tag_q      <= '0;
            vic_q      <= '0;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            case (state)
                S_CLEAR: begin
                    for (int w = 0; w < WAYS; w++) begin
                        valid_mem[clr_idx][w] <= 1'b0;
                        age_mem[clr_idx][w]   <= AGE_W'(w);
                    end
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == IDX_W'(SETS - 1)) begin
                        state     <= S_IDLE;
                        cmd_ready <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_q     <= n;
                        idx_q     <= add_in[OFF_W+IDX_W-1:OFF_W];
                        tag_q     <= add_in[ADDR_W-1:OFF_W+IDX_W];
                        cmd_ready <= 1'b0;
                        state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    case (cmd_q)
                        CMD_FETCH: begin
                            if (hit_found) begin
                                hit <= 1'b1;
                                if (hit_count != '1) hit_count <= hit_count + 1'b1;
                                for (int w = 0; w < WAYS; w++) begin
                                    if (AGE_W'(w) == touch_way)
                                        age_mem[idx_q][w] <= '0;
                                    else if (age_mem[idx_q][w] < touch_age)
                                        age_mem[idx_q][w] <= age_mem[idx_q][w] + 1'b1;
                                end
                                cmd_ready <= 1'b1;
                                state     <= S_IDLE;
                            end else begin
                                miss <= 1'b1;
                                if (miss_count != '1) miss_count <= miss_count + 1'b1;
                                vic_q    <= victim;
                                mem_req  <= 1'b1;
                                mem_addr <= {tag_q, idx_q, {OFF_W{1'b0}}};
                                state    <= S_FILL;
                            end
                        end
                        CMD_INVAL: begin
                            if (hit_found) valid_mem[idx_q][hit_way] <= 1'b0;
                            cmd_ready <= 1'b1;
                            state     <= S_IDLE;
                        end
                        CMD_RESET: begin
                            hit_count  <= '0;
                            miss_count <= '0;
                            clr_idx    <= '0;
                            state      <= S_CLEAR;
                        end
                        default: begin
                            cmd_ready <= 1'b1;
                            state     <= S_IDLE;
                        end
                    endcase
                end
                S_FILL: begin
                    if (mem_ack) begin
                        tag_mem[idx_q][vic_q]   <= tag_q;
                        valid_mem[idx_q][vic_q] <= 1'b1;
                        for (int w = 0; w < WAYS; w++) begin
                            if (AGE_W'(w) == touch_way)
                                age_mem[idx_q][w] <= '0;
                            else if (age_mem[idx_q][w] < touch_age)
                                age_mem[idx_q][w] <= age_mem[idx_q][w] + 1'b1;
                        end
                        mem_req   <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    clr_idx <= '0;
                    state   <= S_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ins_cache_nway.sv
// tb/tb_ins_cache_nway.sv - self-checking bench for ins_cache_nway against a recency-list model
module tb_ins_cache_nway;

    localparam int SETS = 4;
    localparam int WAYS = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  n = 4'd0;
    logic [31:0] add_in = 32'd0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic        hit;
    logic        miss;
    logic [3:0]  hit_count;
    logic [3:0]  miss_count;

    int tests = 0;
    int fails = 0;

    // Reference: per set, resident tags ordered most- to least-recently used
    logic [23:0] m_tag [SETS][WAYS];
    int          m_n   [SETS];
    int          m_hc = 0;
    int          m_mc = 0;

    ins_cache_nway #(
        .ADDR_W(32), .SETS(SETS), .WAYS(WAYS), .LINE_BYTES(64), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .n(n), .add_in(add_in), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .hit(hit), .miss(miss),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_clear();
        for (int s = 0; s < SETS; s++) m_n[s] = 0;
        m_hc = 0;
        m_mc = 0;
    endtask

    function automatic int m_find(input int s, input logic [23:0] t);
        for (int i = 0; i < m_n[s]; i++)
            if (m_tag[s][i] == t) return i;
        return -1;
    endfunction

    task automatic m_touch(input int s, input int pos);
        logic [23:0] tmp;
        tmp = m_tag[s][pos];
        for (int i = pos; i > 0; i--) m_tag[s][i] = m_tag[s][i-1];
        m_tag[s][0] = tmp;
    endtask

    task automatic m_insert(input int s, input logic [23:0] t);
        int last;
        last = (m_n[s] < WAYS) ? m_n[s] : WAYS - 1;
        for (int i = last; i > 0; i--) m_tag[s][i] = m_tag[s][i-1];
        m_tag[s][0] = t;
        if (m_n[s] < WAYS) m_n[s]++;
    endtask

    task automatic m_remove(input int s, input int pos);
        for (int i = pos; i < m_n[s] - 1; i++) m_tag[s][i] = m_tag[s][i+1];
        m_n[s]--;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_hit_count"}, 32'(hit_count), 32'(m_hc));
        check({tag, "_miss_count"}, 32'(miss_count), 32'(m_mc));
    endtask

    // Issue one command; returns at cycle T+2
    task automatic send(input logic [3:0] code, input logic [31:0] a);
        int guard;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        n = code;
        add_in = a;
        tick();
        cmd_valid = 1'b0;
        check("lookup_busy", 32'(cmd_ready), 32'd0);
        tick();
    endtask

    task automatic count_clear(input string tag);
        int cnt;
        cnt = 0;
        while (cmd_ready !== 1'b1 && cnt < 50) begin
            cnt++;
            tick();
        end
        check({tag, "_clear_len"}, 32'(cnt), 32'(SETS));
    endtask

    task automatic fetch(input logic [31:0] a, input int ack_dly);
        int s;
        int pos;
        s = int'(a[7:6]);
        pos = m_find(s, a[31:8]);
        send(4'd2, a);
        check("fetch_hit", 32'(hit), 32'(pos >= 0));
        check("fetch_miss", 32'(miss), 32'(pos < 0));
        if (pos >= 0) begin
            m_touch(s, pos);
            if (m_hc < 15) m_hc++;
            check("hit_ready", 32'(cmd_ready), 32'd1);
        end else begin
            if (m_mc < 15) m_mc++;
            check("miss_req", 32'(mem_req), 32'd1);
            check("miss_addr", mem_addr, {a[31:6], 6'b0});
            for (int i = 0; i < ack_dly; i++) tick();
            check("req_held", 32'(mem_req), 32'd1);
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            check("ack_req_drop", 32'(mem_req), 32'd0);
            check("ack_ready", 32'(cmd_ready), 32'd1);
            check("miss_one_cycle", 32'(miss), 32'd0);
            m_insert(s, a[31:8]);
        end
        check_counts("fetch");
    endtask

    task automatic invalidate(input logic [31:0] a);
        int s;
        int pos;
        s = int'(a[7:6]);
        pos = m_find(s, a[31:8]);
        send(4'd3, a);
        check("inval_pulse", 32'({hit, miss}), 32'd0);
        check("inval_ready", 32'(cmd_ready), 32'd1);
        check_counts("inval");
        if (pos >= 0) m_remove(s, pos);
    endtask

    task automatic other_cmd(input logic [3:0] code, input logic [31:0] a);
        send(code, a);
        check("ignored_pulse", 32'({hit, miss}), 32'd0);
        check("ignored_ready", 32'(cmd_ready), 32'd1);
        check_counts("ignored");
    endtask

    task automatic reset_cmd(input logic [31:0] a);
        send(4'd8, a);
        m_clear();
        check("rcmd_ready", 32'(cmd_ready), 32'd0);
        check_counts("rcmd");
        count_clear("rcmd");
    endtask

    task automatic hard_reset();
        reset = 1'b1;
        cmd_valid = 1'b0;
        mem_ack = 1'b0;
        tick();
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_pulses", 32'({hit, miss}), 32'd0);
        m_clear();
        check_counts("rst");
        reset = 1'b0;
        count_clear("rst");
    endtask

    initial begin
        logic [31:0] a;
        int r;
        int code;
        m_clear();
        tick();
        hard_reset();

        // Cold miss then hit in the same line
        fetch(32'h1000, 3);
        fetch(32'h1004, 0);
        check("cold_hit_count", 32'(hit_count), 32'd1);
        check("cold_miss_count", 32'(miss_count), 32'd1);

        // LRU eviction in set 0
        fetch(32'h000, 1);
        fetch(32'h100, 0);
        fetch(32'h200, 2);
        fetch(32'h300, 0);
        fetch(32'h000, 0);
        fetch(32'h400, 1);
        fetch(32'h000, 0);
        fetch(32'h200, 0);
        fetch(32'h300, 0);
        check("lru_keep_hit", 32'(hit), 32'd1);
        fetch(32'h100, 0);

        // Invalidate resident and non-resident lines
        invalidate(32'h200);
        fetch(32'h200, 2);
        invalidate(32'h900);
        fetch(32'h000, 0);

        // Reset during a fill abandons it and ignores a late ack
        send(4'd2, 32'h2000);
        check("midfill_miss", 32'(miss), 32'd1);
        check("midfill_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midfill_req_drop", 32'(mem_req), 32'd0);
        check("midfill_ready", 32'(cmd_ready), 32'd0);
        m_clear();
        check_counts("midfill");
        mem_ack = 1'b1;
        count_clear("midfill");
        mem_ack = 1'b0;
        check("late_ack_req", 32'(mem_req), 32'd0);
        fetch(32'h000, 0);
        fetch(32'h300, 1);

        // Ignored codes and counter saturation
        other_cmd(4'd4, 32'h000);
        other_cmd(4'd0, 32'h300);
        fetch(32'h040, 0);
        for (int i = 0; i < 20; i++) fetch(32'h040 + 32'(i), 0);
        check("hit_saturated", 32'(hit_count), 32'd15);
        reset_cmd(32'h0);
        fetch(32'h040, 0);

        // Randomized mix over a small address pool
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            a = (32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 3)) << 6) |
                32'($urandom_range(0, 63));
            if (r < 70) begin
                fetch(a, int'($urandom_range(0, 3)));
            end else if (r < 88) begin
                invalidate(a);
            end else if (r < 97) begin
                code = int'($urandom_range(0, 15));
                if (code == 2 || code == 3 || code == 8) code = 4;
                other_cmd(4'(code), a);
            end else begin
                reset_cmd(a);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
